// File: rtl/ika2151_bus_write_sched.sv
// rtl/ika2151_bus_write_sched.sv - queued IKA2151 CPU-bus register write scheduler
//
// Queues (register address, data) pairs and replays each one on the IKA2151 CPU bus as an
// address write (A0=0) followed by a data write (A0=1), holding setup, strobe and
// post-write wait times so the chip register file is never written while busy. All bus
// timing is counted in phiM ticks: i_EMUCLK rising edges with i_phiM_PCEN_n low.
//
// Optional build macro: IKA2151_WSCHED_BUSY_POLL_EN
//   Defined   : the fixed post-data wait is replaced by status reads polling busy (i_D[7]).
//   Undefined : fixed DATA_WAIT_TK wait, i_D unused, o_RD_n tied high.
//
// Ports
//   i_EMUCLK       master clock, all flops on its rising edge
//   i_RST          asynchronous reset, active high
//   i_phiM_PCEN_n  phiM clock enable (active low), shared with the IKA2151
//   i_PUSH_VALID   host offers an entry; accepted when o_PUSH_READY is also high
//   o_PUSH_READY   FIFO not full
//   i_PUSH_ADDR    register address of the offered entry
//   i_PUSH_DATA    register data of the offered entry
//   o_CS_n/o_WR_n/o_RD_n/o_A0/o_D  registered IKA2151 bus drive
//   i_D            IKA2151 data out; bit 7 is the busy flag
//   o_IDLE         FIFO empty and FSM idle
//   o_LEVEL        FIFO occupancy
module ika2151_bus_write_sched #(
    parameter int DEPTH        = 16,
    parameter int STROBE_TK    = 2,
    parameter int ADDR_WAIT_TK = 4,
    parameter int DATA_WAIT_TK = 68,
    parameter int ADDR_SKIP    = 1
) (
    input  logic                     i_EMUCLK,
    input  logic                     i_RST,
    input  logic                     i_phiM_PCEN_n,
    input  logic                     i_PUSH_VALID,
    output logic                     o_PUSH_READY,
    input  logic [7:0]               i_PUSH_ADDR,
    input  logic [7:0]               i_PUSH_DATA,
    output logic                     o_CS_n,
    output logic                     o_WR_n,
    output logic                     o_RD_n,
    output logic                     o_A0,
    output logic [7:0]               o_D,
    input  logic [7:0]               i_D,
    output logic                     o_IDLE,
    output logic [$clog2(DEPTH):0]   o_LEVEL
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Tick counter is 8 bits and saturating; a zero wait is stretched to one tick.
    function automatic logic [7:0] tk_lim(input int n);
        if (n < 1) return 8'd1;
        else if (n > 255) return 8'd255;
        else return 8'(n);
    endfunction

    localparam logic [7:0] STRB_LIM = tk_lim(STROBE_TK);
    localparam logic [7:0] AW_LIM   = tk_lim(ADDR_WAIT_TK);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_A_SETUP = 4'd1;
    localparam logic [3:0] ST_A_STRB  = 4'd2;
    localparam logic [3:0] ST_A_WAIT  = 4'd3;
    localparam logic [3:0] ST_D_SETUP = 4'd4;
    localparam logic [3:0] ST_D_STRB  = 4'd5;
`ifdef IKA2151_WSCHED_BUSY_POLL_EN
    localparam logic [3:0] ST_POLL_RD  = 4'd6;
    localparam logic [3:0] ST_POLL_REL = 4'd7;
`else
    localparam logic [3:0] ST_D_WAIT  = 4'd6;
    localparam logic [7:0] DW_LIM     = tk_lim(DATA_WAIT_TK);
`endif

    // FIFO
    logic [7:0]    mem_addr [DEPTH];
    logic [7:0]    mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [7:0]    head_addr;
    logic [7:0]    head_data;

    // FSM and bus registers
    logic [3:0] state;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic       tick;
    logic [7:0] hold_addr;
    logic [7:0] hold_data;
    logic [7:0] last_addr;
    logic       last_valid;
    logic       cs_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] d;
`ifdef IKA2151_WSCHED_BUSY_POLL_EN
    logic       rd_n;
    logic       poll_busy;
    logic [7:0] poll_num;
`else
    logic       unused_d;
    assign unused_d = ^i_D;
`endif

    assign tick         = ~i_phiM_PCEN_n;
    assign cnt_inc      = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign o_PUSH_READY = (count != CW'(DEPTH));
    assign push         = i_PUSH_VALID & o_PUSH_READY;
    assign pop          = (state == ST_IDLE) && (count != '0);
    assign head_addr    = mem_addr[rd_ptr];
    assign head_data    = mem_data[rd_ptr];

    always_ff @(posedge i_EMUCLK) begin
        if (push) begin
            mem_addr[wr_ptr] <= i_PUSH_ADDR;
            mem_data[wr_ptr] <= i_PUSH_DATA;
        end
    end

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Strobe states: the first tick drops the strobe, it is released once cnt reaches the
    // strobe length, so the low time is exactly STRB_LIM ticks. Wait states are entered
    // with cnt=1 on the releasing tick.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hold_addr  <= '0;
            hold_data  <= '0;
            last_addr  <= '0;
            last_valid <= 1'b0;
            cs_n       <= 1'b1;
            wr_n       <= 1'b1;
            a0         <= 1'b0;
            d          <= '0;
`ifdef IKA2151_WSCHED_BUSY_POLL_EN
            rd_n       <= 1'b1;
            poll_busy  <= 1'b0;
            poll_num   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    // Pop is a plain clock edge; the bus only moves on the next tick.
                    if (pop) begin
                        hold_addr <= head_addr;
                        hold_data <= head_data;
                        if ((ADDR_SKIP != 0) && last_valid && (head_addr == last_addr))
                            state <= ST_D_SETUP;
                        else
                            state <= ST_A_SETUP;
                    end
                end
                ST_A_SETUP: if (tick) begin
                    cs_n  <= 1'b0;
                    a0    <= 1'b0;
                    d     <= hold_addr;
                    cnt   <= '0;
                    state <= ST_A_STRB;
                end
                ST_A_STRB: if (tick) begin
                    if (cnt == 8'd0) begin
                        wr_n <= 1'b0;
                        cnt  <= 8'd1;
                    end else if (cnt >= STRB_LIM) begin
                        // D is left on the bus past the release for hold time.
                        wr_n  <= 1'b1;
                        cs_n  <= 1'b1;
                        cnt   <= 8'd1;
                        state <= ST_A_WAIT;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_A_WAIT: if (tick) begin
                    // The data setup is applied on the tick that ends the wait, so the
                    // data phase setup tick lands right after the ADDR_WAIT_TK idle ticks.
                    if (cnt >= AW_LIM) begin
                        last_addr  <= hold_addr;
                        last_valid <= 1'b1;
                        cs_n       <= 1'b0;
                        a0         <= 1'b1;
                        d          <= hold_data;
                        cnt        <= '0;
                        state      <= ST_D_STRB;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_D_SETUP: if (tick) begin
                    cs_n  <= 1'b0;
                    a0    <= 1'b1;
                    d     <= hold_data;
                    cnt   <= '0;
                    state <= ST_D_STRB;
                end
                ST_D_STRB: if (tick) begin
                    if (cnt == 8'd0) begin
                        wr_n <= 1'b0;
                        cnt  <= 8'd1;
                    end else if (cnt >= STRB_LIM) begin
                        wr_n  <= 1'b1;
                        cs_n  <= 1'b1;
                        cnt   <= 8'd1;
`ifdef IKA2151_WSCHED_BUSY_POLL_EN
                        // Enter the release state as if busy so the first read follows
                        // after one tick with CS_n high.
                        poll_busy <= 1'b1;
                        poll_num  <= '0;
                        state     <= ST_POLL_REL;
`else
                        state <= ST_D_WAIT;
`endif
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
`ifdef IKA2151_WSCHED_BUSY_POLL_EN
                ST_POLL_RD: if (tick) begin
                    if (cnt >= STRB_LIM) begin
                        rd_n      <= 1'b1;
                        cs_n      <= 1'b1;
                        poll_busy <= i_D[7];
                        state     <= ST_POLL_REL;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_POLL_REL: if (tick) begin
                    if (poll_busy && (poll_num != 8'hFF)) begin
                        cs_n     <= 1'b0;
                        a0       <= 1'b1;
                        rd_n     <= 1'b0;
                        poll_num <= poll_num + 8'd1;
                        cnt      <= 8'd1;
                        state    <= ST_POLL_RD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
`else
                ST_D_WAIT: if (tick) begin
                    if (cnt >= DW_LIM) state <= ST_IDLE;
                    else               cnt   <= cnt_inc;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_CS_n  = cs_n;
    assign o_WR_n  = wr_n;
    assign o_A0    = a0;
    assign o_D     = d;
`ifdef IKA2151_WSCHED_BUSY_POLL_EN
    assign o_RD_n  = rd_n;
`else
    assign o_RD_n  = 1'b1;
`endif
    assign o_IDLE  = (state == ST_IDLE) && (count == '0);
    assign o_LEVEL = count;

endmodule

// File: tb/tb_ika2151_bus_write_sched.sv
// tb/tb_ika2151_bus_write_sched.sv - directed self-checking bench for ika2151_bus_write_sched
module tb_ika2151_bus_write_sched;

    localparam int STB = 2;
    localparam int AWT = 4;
    localparam int DWT = 68;

    logic       clk = 1'b0;
    logic       rst;
    logic       pcen_n = 1'b1;
    logic       push_valid;
    logic       push_ready;
    logic [7:0] push_addr;
    logic [7:0] push_data;
    logic       cs_n, wr_n, rd_n, a0, idle;
    logic [7:0] d_out;
    logic [7:0] chip_d;
    logic [4:0] level;

    int total = 0;
    int bad   = 0;

    int pcen_div   = 1;
    int pcen_phase = 0;
    int clk_cnt    = 0;
    int tick_cnt   = 0;
    int offtick    = 0;
    int skip_off   = 1;
    int rd_done    = 0;
    int rd_fall_total = 0;
    int busy_polls = 0;

    int ev_a0[$], ev_d[$], ev_cs[$], ev_ft[$], ev_rt[$], ev_fc[$], ev_rc[$];
    int rd_a0[$], rd_rt[$];

    assign chip_d = (rd_done < busy_polls) ? 8'h80 : 8'h00;

    ika2151_bus_write_sched #(
        .DEPTH(16), .STROBE_TK(STB), .ADDR_WAIT_TK(AWT), .DATA_WAIT_TK(DWT), .ADDR_SKIP(1)
    ) dut (
        .i_EMUCLK(clk), .i_RST(rst), .i_phiM_PCEN_n(pcen_n),
        .i_PUSH_VALID(push_valid), .o_PUSH_READY(push_ready),
        .i_PUSH_ADDR(push_addr), .i_PUSH_DATA(push_data),
        .o_CS_n(cs_n), .o_WR_n(wr_n), .o_RD_n(rd_n), .o_A0(a0), .o_D(d_out),
        .i_D(chip_d), .o_IDLE(idle), .o_LEVEL(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // phiM enable: low one clock in every pcen_div, held high when pcen_div is 0
    initial begin
        forever begin
            @(negedge clk);
            if (pcen_div == 0) pcen_n = 1'b1;
            else begin
                pcen_phase = (pcen_phase + 1) % pcen_div;
                pcen_n = (pcen_phase != 0);
            end
        end
    end

    // Bus monitor: samples just after each rising edge, logs WR/RD pulses and any
    // bus change on an edge that was not a tick.
    initial begin
        logic [11:0] prev_bus;
        logic [11:0] bus;
        logic prev_wr, prev_rd, is_tick;
        int cur_a0, cur_d, cur_cs, cur_ft, cur_fc, cur_ra0;
        prev_bus = 12'hE00; prev_wr = 1'b1; prev_rd = 1'b1;
        cur_a0 = 0; cur_d = 0; cur_cs = 0; cur_ft = 0; cur_fc = 0; cur_ra0 = 0;
        forever begin
            @(posedge clk);
            #1;
            clk_cnt++;
            is_tick = !pcen_n;
            if (is_tick) tick_cnt++;
            bus = {cs_n, wr_n, rd_n, a0, d_out};
            if (skip_off == 0 && bus !== prev_bus && !is_tick) offtick++;
            prev_bus = bus;
            if (prev_wr && !wr_n) begin
                cur_a0 = int'(a0); cur_d = int'(d_out); cur_cs = int'(cs_n);
                cur_ft = tick_cnt; cur_fc = clk_cnt;
            end
            if (!prev_wr && wr_n) begin
                ev_a0.push_back(cur_a0); ev_d.push_back(cur_d); ev_cs.push_back(cur_cs);
                ev_ft.push_back(cur_ft); ev_rt.push_back(tick_cnt);
                ev_fc.push_back(cur_fc); ev_rc.push_back(clk_cnt);
            end
            if (prev_rd && !rd_n) begin
                cur_ra0 = int'(a0);
                rd_fall_total++;
            end
            if (!prev_rd && rd_n) begin
                rd_done++;
                rd_a0.push_back(cur_ra0);
                rd_rt.push_back(tick_cnt);
            end
            prev_wr = wr_n;
            prev_rd = rd_n;
        end
    end

    task automatic clear_events();
        ev_a0.delete(); ev_d.delete(); ev_cs.delete(); ev_ft.delete();
        ev_rt.delete(); ev_fc.delete(); ev_rc.delete();
        rd_a0.delete(); rd_rt.delete();
        rd_done = 0;
    endtask

    // Called just after a falling edge; returns at the falling edge after acceptance
    // with push_valid still high so calls can run back-to-back.
    task automatic push_entry(input logic [7:0] ad, input logic [7:0] dt);
        int g = 0;
        push_valid = 1'b1;
        push_addr  = ad;
        push_data  = dt;
        while (!push_ready && g < 4000) begin
            @(negedge clk);
            g++;
        end
        check("push_ready", push_ready, 1);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int limit, output int t);
        int g = 0;
        while (!idle && g < limit) begin
            @(negedge clk);
            g++;
        end
        check("wait_idle", idle, 1);
        t = tick_cnt;
    endtask

    task automatic check_ev(input string tag, input int k, input int ea0, input int ed);
        if (k < ev_a0.size()) begin
            check({tag, "_a0"}, ev_a0[k], ea0);
            check({tag, "_d"}, ev_d[k], ed);
        end
    endtask

    initial begin
        int g, pop_tick, idle_tick;
        rst = 1'b1; push_valid = 1'b0; push_addr = '0; push_data = '0;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g, pop_tick, idle_tick;
        rst = 1'b1; push_valid = 1'b0; push_addr = '0; push_data = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_wr_n", wr_n, 1);
        check("rst_rd_n", rd_n, 1);
        check("rst_a0", a0, 0);
        check("rst_d", d_out, 8'h00);
        check("rst_ready", push_ready, 1);
        check("rst_idle", idle, 1);
        check("rst_level", level, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        skip_off = 0;

        // Single write, tick every clock
        clear_events();
        push_entry(8'h20, 8'hC7);
        push_valid = 1'b0;
        g = 0;
        while (level != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        pop_tick = tick_cnt;
        wait_idle(2000, idle_tick);
        check("t1_nev", ev_a0.size(), 2);
        check_ev("t1_addr", 0, 0, 8'h20);
        check_ev("t1_data", 1, 1, 8'hC7);
        if (ev_a0.size() >= 2) begin
            check("t1_cs_a", ev_cs[0], 0);
            check("t1_cs_d", ev_cs[1], 0);
            check("t1_wa", ev_rt[0] - ev_ft[0], STB);
            check("t1_wd", ev_rt[1] - ev_ft[1], STB);
            // address wait plus the data setup tick between the two strobes
            check("t1_gap", ev_ft[1] - ev_rt[0], AWT + 1);
            // after the pop edge: one clock to the setup tick, then 2+STB+AWT+STB ticks
            check("t1_lat", ev_rt[1] - pop_tick, 1 + (2 + STB + AWT + STB));
`ifndef IKA2151_WSCHED_BUSY_POLL_EN
            check("t1_dwait", idle_tick - ev_rt[1], DWT);
`endif
        end

        // Fill the FIFO while ticks are stopped; the first entry is already popped
        pcen_div = 0;
        repeat (2) @(negedge clk);
        clear_events();
        for (int i = 0; i < 17; i++) push_entry(8'(8'h40 + i), 8'(8'h90 + i));
        check("fifo_level_full", level, 16);
        check("fifo_ready_full", push_ready, 0);
        push_addr = 8'h51;
        push_data = 8'hA1;
        repeat (5) @(negedge clk);
        check("fifo_held_level", level, 16);
        check("fifo_held_ready", push_ready, 0);
        check("fifo_frozen", ev_a0.size(), 0);
        pcen_div = 1;
        push_entry(8'h51, 8'hA1);
        push_valid = 1'b0;
        wait_idle(4000, idle_tick);
        check("fifo_nev", ev_a0.size(), 36);
        for (int i = 0; i < 18; i++) begin
            check_ev($sformatf("fifo_a%0d", i), 2 * i, 0, 8'h40 + i);
            check_ev($sformatf("fifo_d%0d", i), 2 * i + 1, 1, 8'h90 + i);
        end
        check("fifo_ready_empty", push_ready, 1);

        // Repeated address skips the address phase
        clear_events();
        push_entry(8'h08, 8'h01);
        push_entry(8'h08, 8'h79);
        push_valid = 1'b0;
        wait_idle(2000, idle_tick);
        check("skip_nev", ev_a0.size(), 3);
        check_ev("skip_addr", 0, 0, 8'h08);
        check_ev("skip_d1", 1, 1, 8'h01);
        check_ev("skip_d2", 2, 1, 8'h79);

        // Reset in the middle of an address strobe
        clear_events();
        push_entry(8'h77, 8'h11);
        push_entry(8'h77, 8'h22);
        push_valid = 1'b0;
        g = 0;
        while (wr_n && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("rst_mid_strb", wr_n, 0);
        check("rst_mid_a0", a0, 0);
        skip_off = 1;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_wr_n", wr_n, 1);
        check("rst_mid_cs_n", cs_n, 1);
        check("rst_mid_level", level, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_events();
        skip_off = 0;
        push_entry(8'h08, 8'h66);
        push_valid = 1'b0;
        wait_idle(2000, idle_tick);
        check("rst_after_nev", ev_a0.size(), 2);
        check_ev("rst_after_addr", 0, 0, 8'h08);
        check_ev("rst_after_data", 1, 1, 8'h66);

        // One tick every fourth clock: waveforms stretch by 4
        pcen_div = 4;
        repeat (4) @(negedge clk);
        clear_events();
        push_entry(8'h5A, 8'hA5);
        push_valid = 1'b0;
        wait_idle(3000, idle_tick);
        check("div4_nev", ev_a0.size(), 2);
        check_ev("div4_addr", 0, 0, 8'h5A);
        check_ev("div4_data", 1, 1, 8'hA5);
        if (ev_a0.size() >= 2) begin
            check("div4_wa_clk", ev_rc[0] - ev_fc[0], 4 * STB);
            check("div4_wd_clk", ev_rc[1] - ev_fc[1], 4 * STB);
            check("div4_gap_clk", ev_fc[1] - ev_rc[0], 4 * (AWT + 1));
        end
        check("offtick_edges", offtick, 0);
        pcen_div = 1;
        repeat (2) @(negedge clk);

`ifdef IKA2151_WSCHED_BUSY_POLL_EN
        // Busy for three status reads, clear on the fourth
        clear_events();
        busy_polls = 3;
        push_entry(8'h12, 8'h34);
        push_entry(8'h13, 8'h35);
        push_valid = 1'b0;
        wait_idle(3000, idle_tick);
        check("poll_nev", ev_a0.size(), 4);
        check_ev("poll_a1", 0, 0, 8'h12);
        check_ev("poll_d1", 1, 1, 8'h34);
        check_ev("poll_a2", 2, 0, 8'h13);
        check_ev("poll_d2", 3, 1, 8'h35);
        check("poll_nrd", rd_a0.size(), 5);
        for (int i = 0; i < rd_a0.size(); i++) check($sformatf("poll_rd_a0_%0d", i), rd_a0[i], 1);
        if (rd_rt.size() >= 4 && ev_ft.size() >= 3) begin
            check("poll_after_data", rd_rt[0] > ev_rt[1], 1);
            check("poll_4th_before_next", rd_rt[3] < ev_ft[2], 1);
        end
        busy_polls = 0;
`else
        check("rd_never_low", rd_fall_total, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
